// File: rtl/csr_counter_bank.sv
// csr_counter_bank: machine-mode cycle/instret counters with mcountinhibit,
// hi/lo 32-bit CSR access, registered read port and illegal-access flag.
module csr_counter_bank #(
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned RETIRE_MAX  = 1,
  parameter logic [2:0]  INHIBIT_RST = 3'b000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [$clog2(RETIRE_MAX+1)-1:0]   retire_cnt,
  input  logic [11:0]                       csr_addr,
  input  logic                              csr_re,
  input  logic                              csr_we,
  input  logic [31:0]                       csr_wdata,
  output logic [31:0]                       csr_rdata,
  output logic                              csr_rvalid,
  output logic                              csr_illegal
);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CYC_LO,
    SEL_CYC_HI,
    SEL_INS_LO,
    SEL_INS_HI,
    SEL_INH
  } sel_e;

  logic [CNT_W-1:0] mcycle_q,   mcycle_d;
  logic [CNT_W-1:0] minstret_q, minstret_d;
  logic [2:0]       inh_q,      inh_d;        // {IR, TM, CY}
  logic [31:0]      rdata_q,    rdata_d;
  logic             rvalid_q,   rvalid_d;
  logic             illegal_q,  illegal_d;

  sel_e        sel;
  logic        ro_addr;
  logic        mapped;
  logic        wr_en;
  logic [31:0] rd_val;
  logic [63:0] cyc_ext;
  logic [63:0] ins_ext;

  // Counters viewed as 64 bits so hi/lo slicing is uniform for any CNT_W;
  // bits above CNT_W are zero and are dropped again on write-back.
  assign cyc_ext = 64'(mcycle_q);
  assign ins_ext = 64'(minstret_q);

  // Address decode: which register is addressed and whether it is read-only.
  always_comb begin
    sel     = SEL_NONE;
    ro_addr = 1'b0;
    case (csr_addr)
      12'hB00: sel = SEL_CYC_LO;
      12'hB80: sel = SEL_CYC_HI;
      12'hB02: sel = SEL_INS_LO;
      12'hB82: sel = SEL_INS_HI;
      12'h320: sel = SEL_INH;
      12'hC00: begin sel = SEL_CYC_LO; ro_addr = 1'b1; end
      12'hC80: begin sel = SEL_CYC_HI; ro_addr = 1'b1; end
      12'hC02: begin sel = SEL_INS_LO; ro_addr = 1'b1; end
      12'hC82: begin sel = SEL_INS_HI; ro_addr = 1'b1; end
      default: ;
    endcase
  end

  assign mapped    = (sel != SEL_NONE);
  assign illegal_d = ((csr_re | csr_we) & ~mapped) | (csr_we & ro_addr);
  assign wr_en     = csr_we & mapped & ~ro_addr;

  // Read mux on current register state; unmapped addresses return zero.
  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_CYC_LO: rd_val = cyc_ext[31:0];
      SEL_CYC_HI: rd_val = cyc_ext[63:32];
      SEL_INS_LO: rd_val = ins_ext[31:0];
      SEL_INS_HI: rd_val = ins_ext[63:32];
      SEL_INH:    rd_val = {29'd0, inh_q};
      default:    rd_val = '0;
    endcase
  end

  assign rdata_d  = csr_re ? rd_val : rdata_q;
  assign rvalid_d = csr_re;

  // Next-state for counters and inhibit: a write to a counter half replaces
  // that counter's increment for the cycle, the other half is held as-is.
  always_comb begin
    mcycle_d   = inh_q[0] ? mcycle_q   : mcycle_q + CNT_W'(1);
    minstret_d = inh_q[2] ? minstret_q : minstret_q + CNT_W'(retire_cnt);
    inh_d      = inh_q;
    if (wr_en) begin
      case (sel)
        SEL_CYC_LO: mcycle_d   = CNT_W'({cyc_ext[63:32], csr_wdata});
        SEL_CYC_HI: mcycle_d   = CNT_W'({csr_wdata, cyc_ext[31:0]});
        SEL_INS_LO: minstret_d = CNT_W'({ins_ext[63:32], csr_wdata});
        SEL_INS_HI: minstret_d = CNT_W'({csr_wdata, ins_ext[31:0]});
        SEL_INH:    inh_d      = csr_wdata[2:0];
        default:    ;
      endcase
    end
  end

  // State and registered read-port update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      inh_q      <= INHIBIT_RST;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      inh_q      <= inh_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      illegal_q  <= illegal_d;
    end
  end

  assign csr_rdata   = rdata_q;
  assign csr_rvalid  = rvalid_q;
  assign csr_illegal = illegal_q;

endmodule

// File: tb/tb_csr_counter_bank.sv
// Directed self-checking bench for csr_counter_bank: a 64-bit instance with
// two-wide retire and a 40-bit instance with single retire.
module tb_csr_counter_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [1:0]  r64 = '0;
  logic [11:0] a64 = '0;
  logic        re64 = 1'b0, we64 = 1'b0;
  logic [31:0] wd64 = '0;
  logic [31:0] rd64;
  logic        rv64, il64;

  logic [0:0]  r40 = '0;
  logic [11:0] a40 = '0;
  logic        re40 = 1'b0, we40 = 1'b0;
  logic [31:0] wd40 = '0;
  logic [31:0] rd40;
  logic        rv40, il40;

  int checks = 0;
  int errors = 0;

  csr_counter_bank #(.CNT_W(64), .RETIRE_MAX(2), .INHIBIT_RST(3'b000)) u_dut64 (
    .clk(clk), .rst(rst), .retire_cnt(r64), .csr_addr(a64), .csr_re(re64),
    .csr_we(we64), .csr_wdata(wd64), .csr_rdata(rd64), .csr_rvalid(rv64),
    .csr_illegal(il64)
  );

  csr_counter_bank #(.CNT_W(40), .RETIRE_MAX(1), .INHIBIT_RST(3'b000)) u_dut40 (
    .clk(clk), .rst(rst), .retire_cnt(r40), .csr_addr(a40), .csr_re(re40),
    .csr_we(we40), .csr_wdata(wd40), .csr_rdata(rd40), .csr_rvalid(rv40),
    .csr_illegal(il40)
  );

  always #5 clk = ~clk;

  // retire_cnt above RETIRE_MAX is outside the contract
  always @(posedge clk) begin
    if (!rst) assert (r64 <= 2'd2) else $error("FAIL retire_contract got=%0d max=2", r64);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc64(input logic re, input logic we, input logic [11:0] a, input logic [31:0] d);
    re64 = re; we64 = we; a64 = a; wd64 = d;
    tick();
    re64 = 1'b0; we64 = 1'b0;
  endtask

  task automatic cyc40(input logic re, input logic we, input logic [11:0] a, input logic [31:0] d);
    re40 = re; we40 = we; a40 = a; wd40 = d;
    tick();
    re40 = 1'b0; we40 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    re64 = 1'b1; a64 = 12'hB00; re40 = 1'b1; a40 = 12'h7FF;
    tick();
    re64 = 1'b0; re40 = 1'b0;
    checks++; if (rd64 !== 32'h0) begin errors++; $display("FAIL rst_rdata64 got=%h exp=%h", rd64, 32'h0); end
    checks++; if (rv64 !== 1'b0) begin errors++; $display("FAIL rst_rvalid64 got=%b exp=0", rv64); end
    checks++; if (il64 !== 1'b0) begin errors++; $display("FAIL rst_illegal64 got=%b exp=0", il64); end
    checks++; if (rv40 !== 1'b0 || il40 !== 1'b0 || rd40 !== 32'h0) begin
      errors++; $display("FAIL rst_outs40 got=%b/%b/%h exp=0/0/0", rv40, il40, rd40); end
    rst = 1'b0;
    repeat (10) tick();
    cyc64(1'b1, 1'b0, 12'hB00, 32'h0);
    checks++; if (rd64 !== 32'd10) begin errors++; $display("FAIL idle10_lo got=%h exp=%h", rd64, 32'd10); end
    checks++; if (rv64 !== 1'b1) begin errors++; $display("FAIL idle10_rvalid got=%b exp=1", rv64); end
    cyc64(1'b1, 1'b0, 12'hB80, 32'h0);
    checks++; if (rd64 !== 32'h0) begin errors++; $display("FAIL idle10_hi got=%h exp=%h", rd64, 32'h0); end
    cyc64(1'b0, 1'b0, 12'h000, 32'h0);
    checks++; if (rv64 !== 1'b0) begin errors++; $display("FAIL rvalid_pulse got=%b exp=0", rv64); end
  endtask

  task automatic test_retire();
    r64 = 2'd2; tick();
    r64 = 2'd1; tick();
    r64 = 2'd0; tick();
    r64 = 2'd2; tick();
    r64 = 2'd0;
    cyc64(1'b1, 1'b0, 12'hC02, 32'h0);
    checks++; if (rd64 !== 32'd5) begin errors++; $display("FAIL instret_sum got=%h exp=%h", rd64, 32'd5); end
    cyc64(1'b1, 1'b0, 12'hC82, 32'h0);
    checks++; if (rd64 !== 32'd0) begin errors++; $display("FAIL instret_hi got=%h exp=%h", rd64, 32'd0); end
    // write cycle itself still retires 2 under the old inhibit
    r64 = 2'd2;
    cyc64(1'b0, 1'b1, 12'h320, 32'h4);
    repeat (3) tick();
    r64 = 2'd0;
    cyc64(1'b1, 1'b0, 12'hC02, 32'h0);
    checks++; if (rd64 !== 32'd7) begin errors++; $display("FAIL instret_inhibit got=%h exp=%h", rd64, 32'd7); end
    cyc64(1'b1, 1'b0, 12'h320, 32'h0);
    checks++; if (rd64 !== 32'h4) begin errors++; $display("FAIL inhibit_rb got=%h exp=%h", rd64, 32'h4); end
    cyc64(1'b0, 1'b1, 12'h320, 32'h0);
    r64 = 2'd1; tick(); r64 = 2'd0;
    cyc64(1'b1, 1'b0, 12'hC02, 32'h0);
    checks++; if (rd64 !== 32'd8) begin errors++; $display("FAIL instret_resume got=%h exp=%h", rd64, 32'd8); end
  endtask

  task automatic test_cycle_inhibit();
    cyc64(1'b0, 1'b1, 12'hB00, 32'h50);
    cyc64(1'b0, 1'b1, 12'h320, 32'h1);
    repeat (3) tick();
    cyc64(1'b1, 1'b0, 12'hB00, 32'h0);
    checks++; if (rd64 !== 32'h51) begin errors++; $display("FAIL cy_inhibit got=%h exp=%h", rd64, 32'h51); end
    cyc64(1'b0, 1'b1, 12'h320, 32'h0);
    tick();
    cyc64(1'b1, 1'b0, 12'hB00, 32'h0);
    checks++; if (rd64 !== 32'h52) begin errors++; $display("FAIL cy_resume got=%h exp=%h", rd64, 32'h52); end
  endtask

  task automatic test_wrap();
    cyc64(1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF);
    cyc64(1'b0, 1'b1, 12'hB80, 32'hFFFF_FFFF);
    cyc64(1'b1, 1'b0, 12'hB80, 32'h0);
    checks++; if (rd64 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_prehi got=%h exp=%h", rd64, 32'hFFFF_FFFF); end
    cyc64(1'b1, 1'b0, 12'hB80, 32'h0);
    checks++; if (rd64 !== 32'h0) begin errors++; $display("FAIL wrap_hi got=%h exp=%h", rd64, 32'h0); end
    cyc64(1'b1, 1'b0, 12'hB00, 32'h0);
    checks++; if (rd64 !== 32'h1) begin errors++; $display("FAIL wrap_lo got=%h exp=%h", rd64, 32'h1); end
    cyc64(1'b0, 1'b1, 12'hB02, 32'hFFFF_FFFF);
    r64 = 2'd2;
    cyc64(1'b0, 1'b1, 12'hB82, 32'hFFFF_FFFF);
    tick();
    r64 = 2'd0;
    cyc64(1'b1, 1'b0, 12'hC02, 32'h0);
    checks++; if (rd64 !== 32'h1) begin errors++; $display("FAIL instret_wrap_lo got=%h exp=%h", rd64, 32'h1); end
    cyc64(1'b1, 1'b0, 12'hC82, 32'h0);
    checks++; if (rd64 !== 32'h0) begin errors++; $display("FAIL instret_wrap_hi got=%h exp=%h", rd64, 32'h0); end
  endtask

  task automatic test_write_precedence();
    cyc64(1'b0, 1'b1, 12'hB02, 32'h20);
    cyc64(1'b0, 1'b1, 12'hB80, 32'h12);
    cyc64(1'b0, 1'b1, 12'hB00, 32'h40);
    r64 = 2'd2;
    cyc64(1'b1, 1'b1, 12'hB00, 32'h100);
    r64 = 2'd0;
    checks++; if (rd64 !== 32'h40 || rv64 !== 1'b1 || il64 !== 1'b0) begin
      errors++; $display("FAIL rw_same got=%h/%b/%b exp=%h/1/0", rd64, rv64, il64, 32'h40); end
    cyc64(1'b1, 1'b0, 12'hB80, 32'h0);
    checks++; if (rd64 !== 32'h12) begin errors++; $display("FAIL wr_other_half got=%h exp=%h", rd64, 32'h12); end
    cyc64(1'b1, 1'b0, 12'hB00, 32'h0);
    checks++; if (rd64 !== 32'h101) begin errors++; $display("FAIL wr_no_inc got=%h exp=%h", rd64, 32'h101); end
    cyc64(1'b1, 1'b0, 12'hC02, 32'h0);
    checks++; if (rd64 !== 32'h22) begin errors++; $display("FAIL other_counter got=%h exp=%h", rd64, 32'h22); end
  endtask

  task automatic test_illegal();
    cyc64(1'b0, 1'b1, 12'hB00, 32'h200);
    cyc64(1'b0, 1'b1, 12'hC00, 32'h0);
    checks++; if (il64 !== 1'b1 || rv64 !== 1'b0) begin
      errors++; $display("FAIL ro_write got=%b/%b exp=1/0", il64, rv64); end
    cyc64(1'b1, 1'b0, 12'h7FF, 32'h0);
    checks++; if (rv64 !== 1'b1 || rd64 !== 32'h0 || il64 !== 1'b1) begin
      errors++; $display("FAIL unmapped_rd got=%b/%h/%b exp=1/%h/1", rv64, rd64, il64, 32'h0); end
    cyc64(1'b1, 1'b1, 12'hC00, 32'h5);
    checks++; if (rv64 !== 1'b1 || rd64 !== 32'h202 || il64 !== 1'b1) begin
      errors++; $display("FAIL ro_rdwr got=%b/%h/%b exp=1/%h/1", rv64, rd64, il64, 32'h202); end
    cyc64(1'b0, 1'b1, 12'h321, 32'hFFFF_FFFF);
    checks++; if (il64 !== 1'b1) begin errors++; $display("FAIL unmapped_wr got=%b exp=1", il64); end
    cyc64(1'b1, 1'b0, 12'hB00, 32'h0);
    checks++; if (rd64 !== 32'h204 || il64 !== 1'b0) begin
      errors++; $display("FAIL ill_nochange got=%h/%b exp=%h/0", rd64, il64, 32'h204); end
    cyc64(1'b1, 1'b0, 12'hC80, 32'h0);
    checks++; if (rd64 !== 32'h12) begin errors++; $display("FAIL ill_hi_kept got=%h exp=%h", rd64, 32'h12); end
    cyc64(1'b1, 1'b0, 12'h320, 32'h0);
    checks++; if (rd64 !== 32'h0) begin errors++; $display("FAIL ill_inh_kept got=%h exp=%h", rd64, 32'h0); end
  endtask

  task automatic test_back_to_back();
    cyc64(1'b0, 1'b1, 12'hB00, 32'h300);
    re64 = 1'b1; a64 = 12'hB00;
    tick();
    checks++; if (rd64 !== 32'h300 || rv64 !== 1'b1) begin errors++; $display("FAIL b2b_0 got=%h/%b exp=%h/1", rd64, rv64, 32'h300); end
    tick();
    checks++; if (rd64 !== 32'h301 || rv64 !== 1'b1) begin errors++; $display("FAIL b2b_1 got=%h/%b exp=%h/1", rd64, rv64, 32'h301); end
    tick();
    checks++; if (rd64 !== 32'h302 || rv64 !== 1'b1) begin errors++; $display("FAIL b2b_2 got=%h/%b exp=%h/1", rd64, rv64, 32'h302); end
    re64 = 1'b0;
    tick();
    checks++; if (rd64 !== 32'h302 || rv64 !== 1'b0) begin errors++; $display("FAIL rdata_hold got=%h/%b exp=%h/0", rd64, rv64, 32'h302); end
  endtask

  task automatic test_cnt40();
    cyc40(1'b0, 1'b1, 12'hB80, 32'hFFFF_FFFF);
    cyc40(1'b1, 1'b0, 12'hB80, 32'h0);
    checks++; if (rd40 !== 32'h0000_00FF) begin errors++; $display("FAIL w40_hi_trunc got=%h exp=%h", rd40, 32'h0000_00FF); end
    cyc40(1'b0, 1'b1, 12'hB80, 32'h1234_5678);
    cyc40(1'b1, 1'b0, 12'hC80, 32'h0);
    checks++; if (rd40 !== 32'h78) begin errors++; $display("FAIL w40_hi_trunc2 got=%h exp=%h", rd40, 32'h78); end
    cyc40(1'b0, 1'b1, 12'hB80, 32'hFF);
    cyc40(1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF);
    cyc40(1'b1, 1'b0, 12'hB00, 32'h0);
    checks++; if (rd40 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL w40_max_lo got=%h exp=%h", rd40, 32'hFFFF_FFFF); end
    cyc40(1'b1, 1'b0, 12'hB80, 32'h0);
    checks++; if (rd40 !== 32'h0) begin errors++; $display("FAIL w40_wrap_hi got=%h exp=%h", rd40, 32'h0); end
    cyc40(1'b1, 1'b0, 12'hB00, 32'h0);
    checks++; if (rd40 !== 32'h1) begin errors++; $display("FAIL w40_wrap_lo got=%h exp=%h", rd40, 32'h1); end
    r40 = 1'b1; repeat (3) tick(); r40 = 1'b0;
    cyc40(1'b1, 1'b0, 12'hC02, 32'h0);
    checks++; if (rd40 !== 32'd3) begin errors++; $display("FAIL w40_instret got=%h exp=%h", rd40, 32'd3); end
    cyc40(1'b0, 1'b1, 12'hC82, 32'h0);
    checks++; if (il40 !== 1'b1) begin errors++; $display("FAIL w40_ro_write got=%b exp=1", il40); end
  endtask

  task automatic test_reset_mid_access();
    rst = 1'b1;
    re40 = 1'b1; a40 = 12'hB00;
    re64 = 1'b1; a64 = 12'h7FF;
    tick();
    re64 = 1'b0;
    checks++; if (rv40 !== 1'b0 || rd40 !== 32'h0) begin
      errors++; $display("FAIL rst_mid40 got=%b/%h exp=0/%h", rv40, rd40, 32'h0); end
    checks++; if (rv64 !== 1'b0 || il64 !== 1'b0) begin
      errors++; $display("FAIL rst_mid64 got=%b/%b exp=0/0", rv64, il64); end
    rst = 1'b0;
    tick();
    re40 = 1'b0;
    checks++; if (rv40 !== 1'b1 || rd40 !== 32'h0) begin
      errors++; $display("FAIL rst_post_rd got=%b/%h exp=1/%h", rv40, rd40, 32'h0); end
    cyc40(1'b1, 1'b0, 12'hB00, 32'h0);
    checks++; if (rd40 !== 32'h1) begin errors++; $display("FAIL rst_post_cnt got=%h exp=%h", rd40, 32'h1); end
  endtask

  initial begin
    test_reset();
    test_retire();
    test_cycle_inhibit();
    test_wrap();
    test_write_precedence();
    test_illegal();
    test_back_to_back();
    test_cnt40();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_counter_bank.md
Name: csr_counter_bank

Overview:
Parametrised successor to the single free-running cycle CSR. It holds the RISC-V cycle and instret counters with configurable width and a multi-retire increment. It adds machine-mode write access and per-counter inhibit (mcountinhibit), and returns reads through a registered port with an illegal-access flag. It sits beside the CSR decode in the core's execute/writeback stage.

Parameters:
CNT_W, 64, counter width in bits; legal range 32..64.
RETIRE_MAX, 1, maximum instructions retired per cycle; legal range 1..4.
INHIBIT_RST, 3'b000, reset value of mcountinhibit bits {IR,TM,CY}. TM is stored but unused.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
retire_cnt  in  $clog2(RETIRE_MAX+1)  instructions retired this cycle
csr_addr  in  12  CSR address
csr_re  in  1  read request
csr_we  in  1  write request
csr_wdata  in  32  write data
csr_rdata  out  32  read data, registered
csr_rvalid  out  1  pulses 1 cycle after an accepted csr_re
csr_illegal  out  1  pulses 1 cycle after a bad access

Behaviour:
- Synchronous reset:
  - mcycle and minstret go to 0.
  - mcountinhibit goes to INHIBIT_RST.
  - csr_rdata goes to 0; csr_rvalid and csr_illegal go to 0.
  - Reset mid-access cancels any pending rvalid/illegal pulse.
- Address map:
  - Read/write: 0xB00 mcycle lo, 0xB80 mcycle hi, 0xB02 minstret lo, 0xB82 minstret hi, 0x320 mcountinhibit.
  - Read-only: 0xC00 cycle lo, 0xC80 cycle hi, 0xC02 instret lo, 0xC82 instret hi.
  - Any other address is unmapped.
- Counting, every cycle outside reset:
  - mcycle += 1 unless inhibit.CY.
  - minstret += retire_cnt unless inhibit.IR.
  - Arithmetic is modulo 2^CNT_W, so all-ones wraps to 0 with no flag.
  - retire_cnt > RETIRE_MAX is out of contract; the bench asserts it never occurs.
- Hi/lo halves:
  - Lo access maps to bits [31:0]; hi access maps to bits [CNT_W-1:32], zero-extended.
  - When CNT_W == 32, a hi read returns 0, a hi write is accepted with no effect, and it is not illegal.
- Writes (csr_we=1, writable address):
  - The addressed half takes csr_wdata (truncated to width for hi) at the next edge.
  - The write replaces that counter's increment for that cycle; there is no increment on top of the written value.
  - The other half of the same counter keeps its value, also with no increment.
  - The other counter counts normally.
  - A write to 0x320 updates bits 0 and 2 only (bit 1 stored). Other bits read 0.
  - The new inhibit value takes effect from the following cycle; the write cycle itself counts under the old inhibit.
- Reads (csr_re=1):
  - csr_rdata is the addressed value sampled before this cycle's update, i.e. the old value even with a simultaneous write or increment.
  - csr_rdata and csr_rvalid are registered, so latency is exactly 1 cycle.
  - Back-to-back reads are supported every cycle.
  - csr_rdata holds its last value when there is no read.
- Simultaneous csr_re and csr_we to the same address: the read returns the old value and the write is applied.
- Illegal access: csr_illegal=1 in the following cycle for:
  - an unmapped address with csr_re or csr_we;
  - csr_we to a 0xCxx address.
- On an illegal access:
  - No state changes.
  - A read returns csr_rvalid=1 with csr_rdata=0.
  - For a legal read combined with a write to a read-only address, the read data is valid and csr_illegal=1.
- No other state; no stall input. The counter paths are two CNT_W adders.

Test Plan:
- Reset, then 10 idle cycles, then read 0xB00 -> csr_rvalid 1 cycle later with csr_rdata=10. Read 0xB80 -> 0. During reset assertion all outputs are 0.
- RETIRE_MAX=2: drive retire_cnt 2,1,0,2 on 4 cycles, then read 0xC02 -> 5. Set inhibit.IR via 0x320 wdata=4, retire 2 for 3 cycles -> instret still 5 while mcycle keeps advancing.
- Wrap: write 0xB00=0xFFFFFFFF and 0xB80=0xFFFFFFFF (CNT_W=64), then 1 cycle later read lo/hi -> 0x00000000/0x00000000, with the sampling timing allowing for the increment.
- Write precedence: csr_we 0xB00 wdata=0x100 in cycle N -> mcycle lo=0x100 at N+1 (no +1). A read of 0xB00 in the same cycle N returns the pre-write value.
- Illegal: write 0xC00 -> csr_illegal pulse, cycle unchanged. Read 0x7FF -> csr_rvalid=1, csr_rdata=0, csr_illegal=1.
- CNT_W=40: write 0xB80=0xFFFFFFFF -> read-back 0x000000FF. Count to 2^40-1 -> next value 0. Synchronous reset asserted between request and response -> no rvalid pulse.
